// File: rtl/ex_muldiv.sv
// EX-stage iterative multiply/divide: 32-step shift-add multiply and restoring divide.
// Define MULDIV_FAST_MULT_EN to replace the multiply iteration with a single-cycle 32x32 multiplier.
module ex_muldiv #(
  parameter logic [7:0] OP_MULT  = 8'b00011000,
  parameter logic [7:0] OP_MULTU = 8'b00011001,
  parameter logic [7:0] OP_DIV   = 8'b00011010,
  parameter logic [7:0] OP_DIVU  = 8'b00011011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  ex_aluop,
  input  logic [31:0] ex_opv1,
  input  logic [31:0] ex_opv2,
  input  logic        annul,
  output logic        stall_req,
  output logic        hilo_we,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div_by_zero
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] opb_q, opb_d;
  logic [31:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic        is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        dbz_q, dbz_d;

  logic        is_md, op_div, op_signed, start;
  logic [31:0] abs1, abs2;

  assign op_div    = (ex_aluop == OP_DIV) || (ex_aluop == OP_DIVU);
  assign op_signed = (ex_aluop == OP_MULT) || (ex_aluop == OP_DIV);
  assign is_md     = op_div || (ex_aluop == OP_MULT) || (ex_aluop == OP_MULTU);
  // rst term keeps stall_req low while reset is held, even with a muldiv op presented
  assign start     = rst && (state_q == S_IDLE) && is_md && !annul;
  assign abs1      = (op_signed && ex_opv1[31]) ? -ex_opv1 : ex_opv1;
  assign abs2      = (op_signed && ex_opv2[31]) ? -ex_opv2 : ex_opv2;

`ifdef MULDIV_FAST_MULT_EN
  logic [63:0] fast_prod;
  assign fast_prod = {{32{op_signed & ex_opv1[31]}}, ex_opv1} *
                     {{32{op_signed & ex_opv2[31]}}, ex_opv2};
`endif

  logic [32:0] mul_sum, div_shift, div_diff;
  logic [31:0] step_hi, step_lo, fix_hi, fix_lo;
  logic [63:0] prod_mag, prod_fix;

  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : 33'd0);
    div_shift = {acc_hi_q, acc_lo_q[31]};
    div_diff  = div_shift - {1'b0, opb_q};
    if (is_div_q) begin
      // no borrow means the shifted partial remainder is >= divisor
      if (!div_diff[32]) begin
        step_hi = div_diff[31:0];
        step_lo = {acc_lo_q[30:0], 1'b1};
      end else begin
        step_hi = div_shift[31:0];
        step_lo = {acc_lo_q[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], acc_lo_q[31:1]};
    end
    prod_mag = {step_hi, step_lo};
    prod_fix = neg_res_q ? -prod_mag : prod_mag;
    if (is_div_q) begin
      fix_hi = neg_rem_q ? -step_hi : step_hi;
      fix_lo = neg_res_q ? -step_lo : step_lo;
    end else begin
      fix_hi = prod_fix[63:32];
      fix_lo = prod_fix[31:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opb_d     = opb_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d  = op_div;
          neg_res_d = op_signed & (ex_opv1[31] ^ ex_opv2[31]);
          neg_rem_d = op_signed & op_div & ex_opv1[31];
          cnt_d     = 6'd0;
          acc_hi_d  = 32'd0;
          if (op_div) begin
            opb_d    = abs2;
            acc_lo_d = abs1;
            if (ex_opv2 == 32'd0) begin
              hi_d    = ex_opv1;
              lo_d    = 32'hFFFF_FFFF;
              dbz_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            opb_d    = abs1;
            acc_lo_d = abs2;
`ifdef MULDIV_FAST_MULT_EN
            hi_d     = fast_prod[63:32];
            lo_d     = fast_prod[31:0];
            state_d  = S_DONE;
`else
            state_d  = S_RUN;
`endif
          end
        end
      end
      S_RUN: begin
        if (annul) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            hi_d    = fix_hi;
            lo_d    = fix_lo;
            cnt_d   = 6'd0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 6'd0;
      opb_q     <= 32'd0;
      acc_hi_q  <= 32'd0;
      acc_lo_q  <= 32'd0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opb_q     <= opb_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign stall_req   = start || ((state_q == S_RUN) && !annul);
  assign hilo_we     = (state_q == S_DONE) && !annul;
  assign hi_o        = hi_q;
  assign lo_o        = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv: driver queues expected HI/LO, a negedge monitor pops on hilo_we.
module tb_ex_muldiv;

  localparam logic [7:0] OP_MULT  = 8'b00011000;
  localparam logic [7:0] OP_MULTU = 8'b00011001;
  localparam logic [7:0] OP_DIV   = 8'b00011010;
  localparam logic [7:0] OP_DIVU  = 8'b00011011;
  localparam logic [7:0] OP_ADD   = 8'h20;
`ifdef MULDIV_FAST_MULT_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  ex_aluop = OP_MULT;
  logic [31:0] ex_opv1 = 32'hFFFF_FFFF;
  logic [31:0] ex_opv2 = 32'd2;
  logic        annul = 1'b0;
  logic        stall_req, hilo_we, div_by_zero;
  logic [31:0] hi_o, lo_o;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    string       name;
  } exp_t;
  exp_t exp_q[$];

  int n_checks = 0;
  int n_fail = 0;

  ex_muldiv dut (
    .clk(clk), .rst(rst), .ex_aluop(ex_aluop), .ex_opv1(ex_opv1), .ex_opv2(ex_opv2),
    .annul(annul), .stall_req(stall_req), .hilo_we(hilo_we), .hi_o(hi_o), .lo_o(lo_o),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every hilo_we consumes exactly one queued expectation
  always @(negedge clk) begin
    if (rst) begin
      if (hilo_we) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_hilo_we", 65'd1, 65'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(e.name, {div_by_zero, hi_o, lo_o}, {e.dbz, e.hi, e.lo});
          $display("op %s: hi=%h lo=%h dbz=%0d", e.name, hi_o, lo_o, div_by_zero);
        end
      end else if (div_by_zero) begin
        chk("dbz_without_we", {64'd0, div_by_zero}, 65'd0);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after DONE
  task automatic run_op(input string name, input logic [7:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input logic edbz, input int estall);
    int n;
    exp_t e;
    e.hi = ehi; e.lo = elo; e.dbz = edbz; e.name = name;
    exp_q.push_back(e);
    ex_aluop = op; ex_opv1 = a; ex_opv2 = b;
    #1;
    n = 0;
    while (stall_req && n < 200) begin
      n++;
      @(posedge clk); #2;
    end
    chk({name, "_stall_cycles"}, 65'(n), 65'(estall));
    @(posedge clk); #1;
    ex_aluop = OP_ADD; ex_opv1 = 32'd5; ex_opv2 = 32'd6;
    #1;
    chk({name, "_no_restart"}, {64'd0, stall_req}, 65'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_stall", {64'd0, stall_req}, 65'd0);
    chk("reset_outputs", {div_by_zero, hi_o, lo_o}, 65'd0);
    chk("reset_we", {64'd0, hilo_we}, 65'd0);
    ex_aluop = OP_ADD;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_add_stall", {64'd0, stall_req}, 65'd0);

    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33);
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 33);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 33);
    run_op("div_by_zero", OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("divu_0_0", OP_DIVU, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFF, 1'b0, 33);
    run_op("mult_m1_2", OP_MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, MUL_STALL);
    run_op("multu_m1_2", OP_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 1'b0, MUL_STALL);
    run_op("mult_min_min", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, MUL_STALL);

    // annul while idle must suppress the start
    ex_aluop = OP_DIV; ex_opv1 = 32'd10; ex_opv2 = 32'd2; annul = 1'b1;
    #1;
    chk("annul_idle_stall", {64'd0, stall_req}, 65'd0);
    @(posedge clk); #2;
    chk("annul_idle_stays", {64'd0, stall_req}, 65'd0);
    annul = 1'b0; ex_aluop = OP_ADD;
    @(posedge clk); #1;

    // annul at RUN step 10 of a DIVU
    ex_aluop = OP_DIVU; ex_opv1 = 32'd1000; ex_opv2 = 32'd7;
    #1;
    repeat (11) @(posedge clk);
    #2;
    chk("run_stall_before_annul", {64'd0, stall_req}, 65'd1);
    annul = 1'b1;
    #1;
    chk("annul_run_stall", {64'd0, stall_req}, 65'd0);
    @(posedge clk); #1;
    annul = 1'b0; ex_aluop = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("add_after_annul", {63'd0, hilo_we, stall_req}, 65'd0);
      @(posedge clk); #1;
    end
    run_op("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0, 33);

    // asynchronous reset mid-RUN
    ex_aluop = OP_DIVU; ex_opv1 = 32'd100; ex_opv2 = 32'd7;
    repeat (6) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_stall", {64'd0, stall_req}, 65'd0);
    chk("rst_we", {64'd0, hilo_we}, 65'd0);
    chk("rst_results", {div_by_zero, hi_o, lo_o}, 65'd0);
    ex_aluop = OP_ADD;
    #3;
    rst = 1'b1;
    @(posedge clk); #2;
    chk("post_rst_idle", {63'd0, hilo_we, stall_req}, 65'd0);
    @(posedge clk); #1;
    run_op("multu_after_rst", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 1'b0, MUL_STALL);

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 65'(exp_q.size()), 65'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
